cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, carry-segmented pipelined carry-lookahead adder/subtractor.
- Successor to the fixed 5-bit registered CLA: adds configurable width, one pipeline stage per carry group, add/sub mode, valid/ready handshake with backpressure, and status flags.
- Sits between operand sources and the result consumer in the arithmetic datapath.
- Sustains one operation per cycle when the output is not stalled.

Parameters:
- WIDTH, 16: operand and sum width in bits. Legal range 4..64.
- BLOCK, 4: bits resolved per carry-lookahead group, which is also bits per pipeline stage. WIDTH % BLOCK must equal 0, otherwise elaboration error.
- NSEG, WIDTH/BLOCK (derived, not overridable): number of carry stages, equal to the latency.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used in add mode only.
- in_sub  in  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, in_cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  sum/difference.
- out_cout  out  1  carry out of MSB (sub: 1 = no borrow).
- out_ovf  out  1  signed overflow = C[WIDTH] ^ C[WIDTH-1].
- out_zero  out  1  out_sum == 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low: sampled on the rising edge of clk; a low sample resets state.
- Reset values:
  - All stage valid bits = 0.
  - out_valid = 0; out_sum = 0; out_cout, out_ovf, out_zero = 0.
  - in_ready = 0 while rst_n is low (combinationally gated).
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv && rst_n.
  - All stage registers load only when adv = 1; when adv = 0 the whole pipe holds.
- Accept: a beat is accepted on an edge where in_valid && in_ready.
  - Stage 0 captures A, B' (B' = B ^ {WIDTH{in_sub}}), c0 (= in_sub ? 1 : in_cin), and valid.
  - If adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Stage k, for k = 0..NSEG-1:
  - Combinationally resolves bits [k*BLOCK +: BLOCK] with BLOCK-bit lookahead from the incoming carry.
  - Registers into stage k+1: the completed lower sum bits, the remaining unresolved operand bits, the group carry-out, C[k*BLOCK+BLOCK-1] (the carry into the last bit of the group, needed for overflow), and valid.
- Output: stage NSEG is the output register.
  - out_sum, out_cout = C[WIDTH], and out_ovf are registered.
  - out_zero is computed from the assembled sum at the final stage and registered alongside it.
- Latency: a beat accepted on edge t appears with out_valid = 1 after edge t+NSEG, absent stalls. Each stall cycle adds one.
- Throughput: 1 beat/cycle; results in strict acceptance order; no drops, no duplicates.
- Stall: while out_valid = 1 and out_ready = 0, out_* stay stable and in_ready = 0.
- Simultaneous accept and emit: when out_valid && out_ready and in_valid in the same cycle, both occur; the pipe shifts by one.
- Bubbles: internal bubbles are not collapsed; a valid = 0 slot still takes a cycle to drain.
- Reset mid-operation: all in-flight beats are discarded. out_valid = 0 on the cycle after the reset edge; no stale result is ever emitted.
- Arithmetic: all operations modulo 2^WIDTH. No sign extension; signedness affects only out_ovf.

Decomposition:
- Shared package cla_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Function nseg(width, block).
  - Elaboration check macro for WIDTH % BLOCK.
- Sub-module cla_block_slice (parameter BLOCK):
  - Combinational; inputs a, b, cin.
  - Outputs sum[BLOCK], cout, and c_msb (the carry into the slice MSB).
  - Uses group P/G lookahead.
  - Instantiated NSEG times in a generate loop.
- Top module holds the stage registers, the handshake, and flag generation.

Test Plan (WIDTH=16, BLOCK=4, NSEG=4):
1. Add 0xFFFF + 0x0001, cin 0, out_ready = 1 → after 4 edges: sum 0x0000, cout 1, zero 1, ovf 0; out_valid high for exactly 1 cycle.
2. Sub 0x8000 − 0x0001 → sum 0x7FFF, cout 1, ovf 1, zero 0. Add 0x7FFF + 0x0001 → sum 0x8000, cout 0, ovf 1.
3. Carry-in across all groups: add 0x0FFF + 0x0000, cin 1 → sum 0x1000, cout 0, ovf 0. Sub 0x0003 − 0x0005 → sum 0xFFFE, cout 0.
4. Eight back-to-back random beats with out_ready = 1 → eight results in consecutive cycles, in order, matching a reference model. in_ready stays 1 throughout.
5. Backpressure: fill the pipe, hold out_ready = 0 for 3 cycles → in_ready = 0, out_* unchanged for 3 cycles. After release, the remaining beats drain in order with no loss or duplication.
6. Reset mid-flight: 3 beats in flight, drive rst_n = 0 for 1 cycle → out_valid = 0 and all outputs 0 next cycle. None of the 3 results ever appears. A new beat after reset has latency exactly 4.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   OP_ADD / OP_SUB : encoding of the in_sub operation select.
//   nseg()          : number of carry stages (= pipeline latency) for a width/group size.
//   CLA_ELAB_CHECK  : elaboration-time legality check for WIDTH/BLOCK, expanded at module scope.

`define CLA_ELAB_CHECK(W, B) \
  if ((B) < 1 || (W) < 4 || (W) > 64 || ((W) % (B)) != 0) begin : g_cla_param_check \
    $error("cla_pipe_adder: WIDTH must be 4..64 and an exact multiple of BLOCK"); \
  end

package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block_slice.sv
// One carry-lookahead group, purely combinational.
//   a, b   : BLOCK-bit operand slices (b already inverted for subtraction)
//   cin    : carry into the group LSB
//   sum    : BLOCK-bit sum slice
//   cout   : carry out of the group MSB
//   c_msb  : carry into the group MSB (pairs with cout for signed overflow)

module cla_block_slice #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             grp_g;
  logic             grp_p;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is formed from the group-prefix generate/propagate of bits [i:0] and cin
  // directly, so no carry depends on a neighbouring carry.
  always_comb begin
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    c[0]  = cin;
    for (int i = 0; i < BLOCK; i++) begin
      grp_g    = g[i] | (p[i] & grp_g);
      grp_p    = grp_p & p[i];
      c[i + 1] = grp_g | (grp_p & cin);
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Carry-segmented pipelined adder/subtractor with valid/ready handshake.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   in_a, in_b           : operands (WIDTH bits)
//   in_cin               : carry-in, add mode only
//   in_sub               : 0 = A+B+cin, 1 = A-B
//   out_valid / out_ready: result handshake
//   out_sum              : sum/difference (mod 2^WIDTH)
//   out_cout             : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              : signed overflow
//   out_zero             : out_sum == 0
// One carry group is resolved per stage; latency is WIDTH/BLOCK cycles. The whole pipe
// advances together whenever the output register is empty or being drained.

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NSEG = nseg(WIDTH, BLOCK);

  `CLA_ELAB_CHECK(WIDTH, BLOCK)

  // Stage k holds the beat about to have group k resolved. Operands are carried at full
  // width; each stage only reads its own group, and s_q accumulates the resolved low bits.
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             c_q [NSEG];
  logic             v_q [NSEG];

  logic [BLOCK-1:0] sl_sum  [NSEG];
  logic             sl_cout [NSEG];
  logic             sl_cmsb [NSEG];
  logic [WIDTH-1:0] s_nxt   [NSEG];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && rst_n;

  // Subtraction is A + ~B + 1; the carry-in port is ignored in that mode.
  assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign c0    = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_slice
    cla_block_slice #(
      .BLOCK(BLOCK)
    ) u_slice (
      .a    (a_q[k][k*BLOCK +: BLOCK]),
      .b    (b_q[k][k*BLOCK +: BLOCK]),
      .cin  (c_q[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k]),
      .c_msb(sl_cmsb[k])
    );
  end

  // Merge each stage's freshly resolved group into its partial sum.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      s_nxt[k]                  = s_q[k];
      s_nxt[k][k*BLOCK +: BLOCK] = sl_sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (adv) begin
      // in_ready == adv here, so in_valid alone marks an accepted beat (else a bubble).
      v_q[0] <= in_valid;
      a_q[0] <= in_a;
      b_q[0] <= b_eff;
      s_q[0] <= '0;
      c_q[0] <= c0;
      for (int k = 1; k < NSEG; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_nxt[k-1];
        c_q[k] <= sl_cout[k-1];
      end
      out_valid_q <= v_q[NSEG-1];
      out_sum_q   <= s_nxt[NSEG-1];
      out_cout_q  <= sl_cout[NSEG-1];
      out_ovf_q   <= sl_cout[NSEG-1] ^ sl_cmsb[NSEG-1];
      out_zero_q  <= (s_nxt[NSEG-1] == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4, latency 4).

module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int n_vec;
  int n_err;

  cla_pipe_adder #(
    .WIDTH(16),
    .BLOCK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single beat in, wait (bounded) for its result; lat counts edges after the accept edge.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output int lat, output logic [15:0] sum,
                         output logic cout, output logic ovf, output logic zero);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum = out_sum; cout = out_cout; ovf = out_ovf; zero = out_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
    n_vec++; if (out_sum !== 16'h0) begin n_err++; $display("FAIL rst_sum: got %h, expected 0000", out_sum); end
    n_vec++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin
      n_err++; $display("FAIL rst_flags: got %b, expected 000", {out_cout, out_ovf, out_zero});
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_add_wrap();
    int lat; logic [15:0] s; logic c, o, z;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, c, o, z);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d, expected 4", lat); end
    n_vec++; if ({s, c, z, o} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wrap_result: got sum %h c%b z%b v%b, expected sum 0000 c1 z1 v0", s, c, z, o);
    end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_one_cycle: got %b, expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] s; logic c, o, z;
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, lat, s, c, o, z);
    n_vec++; if ({s, c, o, z} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sub_ovf: got sum %h c%b v%b z%b, expected sum 7fff c1 v1 z0", s, c, o, z);
    end
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, c, o, z);
    n_vec++; if ({s, c, o, z} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_ovf: got sum %h c%b v%b z%b, expected sum 8000 c0 v1 z0", s, c, o, z);
    end
  endtask

  task automatic test_carry_chain();
    int lat; logic [15:0] s; logic c, o, z;
    run_one(16'h0FFF, 16'h0000, 1'b1, 1'b0, lat, s, c, o, z);
    n_vec++; if ({s, c, o, z} !== {16'h1000, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL cin_chain: got sum %h c%b v%b z%b, expected sum 1000 c0 v0 z0", s, c, o, z);
    end
    // in_cin is driven high here and must be ignored in subtract mode.
    run_one(16'h0003, 16'h0005, 1'b1, 1'b1, lat, s, c, o, z);
    n_vec++; if ({s, c, o, z} !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sub_borrow: got sum %h c%b v%b z%b, expected sum fffe c0 v0 z0", s, c, o, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] es [8];
    logic        vc [8];
    logic        vs [8];
    logic        ec [8];
    int          w;
    va = '{16'h1234, 16'hFFFF, 16'hA5A5, 16'h0000, 16'h8000, 16'h00FF, 16'h7777, 16'hFFF0};
    vb = '{16'h4321, 16'hFFFF, 16'h5A5A, 16'h0001, 16'h8000, 16'h0F01, 16'h1111, 16'h000F};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    es = '{16'h5555, 16'hFFFF, 16'h4B4B, 16'hFFFF, 16'h0000, 16'h1001, 16'h6666, 16'h0000};
    ec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    w = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          in_a = va[i]; in_b = vb[i]; in_cin = vc[i]; in_sub = vs[i];
          in_valid = 1'b1; out_ready = 1'b1;
          #1;
          n_vec++; if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, in_ready);
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int j = 0; j < 8; j++) begin
          n_vec++; if ({out_valid, out_sum, out_cout} !== {1'b1, es[j], ec[j]}) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got v%b sum %h c%b, expected v1 sum %h c%b",
                     j, out_valid, out_sum, out_cout, es[j], ec[j]);
          end
          @(negedge clk);
        end
        n_vec++; if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL b2b_extra: got valid %b, expected 0", out_valid);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    logic [15:0] va [6];
    logic [15:0] es [6];
    int          wi, ri, stall_left;
    logic        seen;
    va = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    es = '{16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656, 16'h6767};
    wi = 0; ri = 0; stall_left = 3;
    for (int cyc = 0; cyc < 60 && ri < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(out_valid && stall_left > 0);
      if (wi < 6) begin
        in_valid = 1'b1; in_a = va[wi]; in_b = 16'h0101; in_cin = 1'b0; in_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        n_vec++; if ({in_ready, out_valid, out_sum, out_cout} !== {1'b0, 1'b1, es[0], 1'b0}) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: got rdy%b v%b sum %h c%b, expected rdy0 v1 sum %h c0",
                   3 - stall_left, in_ready, out_valid, out_sum, out_cout, es[0]);
        end
        stall_left--;
      end
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        n_vec++; if (out_sum !== es[ri]) begin
          n_err++; $display("FAIL bp_order[%0d]: got %h, expected %h", ri, out_sum, es[ri]);
        end
        ri++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (ri !== 6 || wi !== 6 || stall_left !== 0) begin
      n_err++; $display("FAIL bp_counts: got out %0d in %0d stalls-left %0d, expected 6 6 0",
                        ri, wi, stall_left);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL bp_duplicate: got %b, expected 0", seen); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] va [3];
    logic        seen;
    int lat; logic [15:0] s; logic c, o, z;
    va = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = va[i]; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b, expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 20'h0) begin
      n_err++; $display("FAIL mid_rst_outputs: got v%b sum %h c%b v%b z%b, expected all 0",
                        out_valid, out_sum, out_cout, out_ovf, out_zero);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_stale: got %b, expected 0", seen); end
    run_one(16'h0101, 16'h0202, 1'b0, 1'b0, lat, s, c, o, z);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL post_rst_latency: got %0d, expected 4", lat); end
    n_vec++; if ({s, c} !== {16'h0303, 1'b0}) begin
      n_err++; $display("FAIL post_rst_result: got sum %h c%b, expected sum 0303 c0", s, c);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_add_wrap();
    test_overflow();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
